// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider.
package clk_div_pkg;
  localparam logic MODE_TOGGLE  = 1'b0;
  localparam logic MODE_PULSE   = 1'b1;
  localparam int   DEF_WIDTH    = 8;
  localparam int   DEF_CHANNELS = 2;
endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow divisor and mode, registered outputs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_value,
  input  logic             ld_mode,
  output logic             clk_out,
  output logic             tick
);

  logic [WIDTH-1:0] cnt, act_d, shd_d;
  logic             act_mode, shd_mode;
  logic             wrap, apply, nxt_mode;
  logic [WIDTH-1:0] nxt_d;

  // Wrap/apply decode; a load in the same cycle writes straight through to the active copy.
  always_comb begin
    wrap     = en && !sync && (cnt == act_d);
    apply    = wrap || !en || sync;
    nxt_d    = ld ? ld_value : shd_d;
    nxt_mode = ld ? ld_mode  : shd_mode;
  end

  // Counter, divisor shadow/active copies and output generation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      act_d    <= '0;
      shd_d    <= '0;
      act_mode <= MODE_TOGGLE;
      shd_mode <= MODE_TOGGLE;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      shd_d    <= nxt_d;
      shd_mode <= nxt_mode;
      if (apply) begin
        act_d    <= nxt_d;
        act_mode <= nxt_mode;
      end
      if (sync || !en) begin
        cnt     <= '0;
        tick    <= 1'b0;
        clk_out <= 1'b0;
      end else if (wrap) begin
        // The period that just ended uses the mode it was running with.
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= (act_mode == MODE_PULSE) ? 1'b1 : ~clk_out;
      end else begin
        cnt  <= cnt + WIDTH'(1);
        tick <= 1'b0;
        if (act_mode == MODE_PULSE) clk_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// CHANNELS independent programmable dividers sharing one load port and sync strobe.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                div_load,
  input  logic [SELW-1:0]     div_sel,
  input  logic [WIDTH-1:0]    div_value,
  input  logic                div_mode,
  input  logic                sync,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  logic [CHANNELS-1:0] ld;

  // Load decode; div_sel values with no matching channel select nothing.
  always_comb begin
    ld = '0;
    for (int c = 0; c < CHANNELS; c++)
      ld[c] = div_load && (div_sel == SELW'(c));
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    clk_div_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (ch_en[c]),
      .sync     (sync),
      .ld       (ld[c]),
      .ld_value (div_value),
      .ld_mode  (div_mode),
      .clk_out  (clk_out[c]),
      .tick     (tick[c])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus random traffic vs a period-based model.
module tb_clk_div_multi;
  localparam int W  = 8;
  localparam int CH = 3;

  logic          clk, rst_n, div_load, div_mode, sync;
  logic [CH-1:0] ch_en, clk_out, tick;
  logic [1:0]    div_sel;
  logic [W-1:0]  div_value;

  int nvec = 0, nerr = 0;

  // Model: per channel, cycles elapsed in the current period and the period length (D+1).
  int m_el[CH], m_per[CH], m_shper[CH];
  bit m_mode[CH], m_smode[CH], m_out[CH], m_tick[CH];

  clk_div_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .div_load(div_load), .div_sel(div_sel),
    .div_value(div_value), .div_mode(div_mode), .sync(sync), .clk_out(clk_out), .tick(tick)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [CH-1:0] e_out();
    for (int c = 0; c < CH; c++) e_out[c] = m_out[c];
  endfunction
  function automatic logic [CH-1:0] e_tick();
    for (int c = 0; c < CH; c++) e_tick[c] = m_tick[c];
  endfunction

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      bit ld, en, done, nmode;
      int nper;
      ld    = div_load && (int'(div_sel) == c);
      en    = ch_en[c];
      nper  = ld ? int'(div_value) + 1 : m_shper[c];
      nmode = ld ? div_mode : m_smode[c];
      done  = en && !sync && (m_el[c] + 1 == m_per[c]);
      if (!rst_n) begin
        m_el[c] = 0; m_per[c] = 1; m_shper[c] = 1;
        m_mode[c] = 0; m_smode[c] = 0; m_out[c] = 0; m_tick[c] = 0;
      end else begin
        m_shper[c] = nper; m_smode[c] = nmode;
        if (!en || sync) begin
          m_el[c] = 0; m_tick[c] = 0; m_out[c] = 0;
        end else if (done) begin
          m_el[c] = 0; m_tick[c] = 1; m_out[c] = m_mode[c] ? 1'b1 : !m_out[c];
        end else begin
          m_el[c]++; m_tick[c] = 0;
          if (m_mode[c]) m_out[c] = 0;
        end
        if (!en || sync || done) begin
          m_per[c] = nper; m_mode[c] = nmode;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load(input int sel, input int val, input bit mode);
    div_load = 1; div_sel = 2'(sel); div_value = W'(val); div_mode = mode;
    step();
    div_load = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; ch_en = '1; div_load = 1; div_sel = 0; div_value = 8'd9; sync = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if (clk_out !== 3'b000 || tick !== 3'b000) begin
        $display("FAIL reset: clk_out=%b tick=%b, want 000/000", clk_out, tick); nerr++;
      end
    end
    div_load = 0; ch_en = '0; rst_n = 1;
    step();
  endtask

  task automatic test_d0();
    logic prev;
    load(0, 0, 0);
    ch_en = 3'b001;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      nvec++;
      if (tick[0] !== 1'b1 || clk_out[0] === prev || clk_out !== e_out() || tick !== e_tick()) begin
        $display("FAIL d0: clk_out=%b tick=%b, want %b/%b", clk_out, tick, e_out(), e_tick()); nerr++;
      end
      prev = clk_out[0];
    end
    ch_en = 0; step();
  endtask

  task automatic test_toggle_d3();
    int first, hi;
    load(1, 3, 0);
    ch_en = 3'b010;
    first = -1; hi = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (tick[1] && first < 0) first = i;
      if (i > 4 && i <= 12 && clk_out[1]) hi++;
      nvec++;
      if (clk_out !== e_out() || tick !== e_tick()) begin
        $display("FAIL toggle_d3: clk_out=%b tick=%b, want %b/%b", clk_out, tick, e_out(), e_tick()); nerr++;
      end
    end
    nvec++;
    if (first !== 4 || hi !== 4) begin
      $display("FAIL toggle_d3_timing: first=%0d high=%0d, want 4/4", first, hi); nerr++;
    end
    ch_en = 0; step();
  endtask

  task automatic test_load_mid();
    bit want;
    load(0, 4, 0);
    ch_en = 3'b001;
    for (int e = 1; e <= 14; e++) begin
      if (e == 3) begin div_load = 1; div_sel = 0; div_value = 1; div_mode = 0; end
      step();
      div_load = 0;
      want = (e == 5) || (e > 5 && (e - 5) % 2 == 0);
      nvec++;
      if (tick[0] !== want || clk_out !== e_out() || tick !== e_tick()) begin
        $display("FAIL load_mid edge %0d: tick=%b clk_out=%b, want tick0=%b model %b/%b",
                 e, tick, clk_out, want, e_tick(), e_out()); nerr++;
      end
    end
    ch_en = 0; step();
  endtask

  task automatic test_sync();
    int t0, t1, n;
    bit seen;
    load(0, 2, 1);
    load(1, 5, 0);
    ch_en = 3'b011;
    seen = 0; n = 0;
    while (!(seen && m_el[0] + 1 == m_per[0]) && n < 20) begin
      step(); n++;
      if (tick[0]) seen = 1;
      nvec++;
      if (clk_out !== e_out() || tick !== e_tick()) begin
        $display("FAIL sync_pre: clk_out=%b tick=%b, want %b/%b", clk_out, tick, e_out(), e_tick()); nerr++;
      end
    end
    nvec++;
    if (n >= 20) begin $display("FAIL sync_find: no wrap point within 20 cycles, want < 20"); nerr++; end
    sync = 1; step(); sync = 0;
    nvec++;
    if (tick[1:0] !== 2'b00 || clk_out[1:0] !== 2'b00) begin
      $display("FAIL sync_edge: tick=%b clk_out=%b, want 00/00", tick[1:0], clk_out[1:0]); nerr++;
    end
    t0 = -1; t1 = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (tick[0] && t0 < 0) t0 = i;
      if (tick[1] && t1 < 0) t1 = i;
      nvec++;
      if (clk_out !== e_out() || tick !== e_tick()) begin
        $display("FAIL sync_post: clk_out=%b tick=%b, want %b/%b", clk_out, tick, e_out(), e_tick()); nerr++;
      end
    end
    nvec++;
    if (t0 !== 3 || t1 !== 6) begin
      $display("FAIL sync_latency: first ticks %0d/%0d, want 3/6", t0, t1); nerr++;
    end
  endtask

  // Continues from the running ch0 (D=2 pulse) / ch1 (D=5 toggle) state.
  task automatic test_bad_sel_disable();
    int first;
    div_load = 1; div_sel = 2'd3; div_value = W'($urandom_range(0, 255)); div_mode = 1'($urandom);
    step(); div_load = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      nvec++;
      if (clk_out !== e_out() || tick !== e_tick()) begin
        $display("FAIL bad_sel: clk_out=%b tick=%b, want %b/%b", clk_out, tick, e_out(), e_tick()); nerr++;
      end
    end
    ch_en[0] = 0; step();
    nvec++;
    if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
      $display("FAIL disable: clk_out0=%b tick0=%b, want 0/0", clk_out[0], tick[0]); nerr++;
    end
    ch_en[0] = 1; first = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (tick[0] && first < 0) first = i;
    end
    nvec++;
    if (first !== 3) begin $display("FAIL reenable: first tick0 at %0d, want 3", first); nerr++; end
    ch_en = 0; step();
  endtask

  task automatic test_d255_reset();
    int last, gaps, bad;
    load(2, 255, 1);
    ch_en = 3'b100;
    last = 0; gaps = 0; bad = 0;
    for (int i = 1; i <= 800; i++) begin
      step();
      if (clk_out !== e_out() || tick !== e_tick()) bad++;
      if (tick[2]) begin
        if (i - last != 256) bad++;
        last = i; gaps++;
      end
    end
    nvec++;
    if (gaps !== 3 || bad !== 0) begin
      $display("FAIL d255: ticks=%0d errors=%0d, want 3/0", gaps, bad); nerr++;
    end
    rst_n = 0; step(); rst_n = 1;
    nvec++;
    if (clk_out !== 3'b000 || tick !== 3'b000) begin
      $display("FAIL mid_reset: clk_out=%b tick=%b, want 000/000", clk_out, tick); nerr++;
    end
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++;
      if (tick[2] !== 1'b1) begin $display("FAIL post_reset_d0: tick2=%b, want 1", tick[2]); nerr++; end
    end
    ch_en = 0; step();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) ch_en = CH'($urandom);
      div_load  = ($urandom_range(0, 11) == 0);
      div_sel   = 2'($urandom);
      div_value = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      div_mode  = 1'($urandom);
      sync      = ($urandom_range(0, 63) == 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      step();
      nvec++;
      if (clk_out !== e_out() || tick !== e_tick()) begin
        if (bad < 10)
          $display("FAIL random cycle %0d: clk_out=%b tick=%b, want %b/%b", i, clk_out, tick, e_out(), e_tick());
        bad++; nerr++;
      end
    end
    div_load = 0; sync = 0; rst_n = 1;
  endtask

  initial begin
    rst_n = 0; ch_en = 0; div_load = 0; div_sel = 0; div_value = 0; div_mode = 0; sync = 0;
    for (int c = 0; c < CH; c++) begin
      m_el[c] = 0; m_per[c] = 1; m_shper[c] = 1;
      m_mode[c] = 0; m_smode[c] = 0; m_out[c] = 0; m_tick[c] = 0;
    end
    test_reset();
    test_d0();
    test_toggle_d3();
    test_load_mid();
    test_sync();
    test_bad_sel_disable();
    test_d255_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel programmable clock divider; successor to the fixed single-output divider in the TinyTapeout top. It generates CHANNELS independent divided outputs from the single system clock. Each output has a runtime-loadable divisor and a per-channel toggle or pulse mode. Divisor changes are glitch-free, and a phase-sync strobe aligns all channels. It sits between the top-level pin wrapper (ui_in/uio_in drive configuration) and uo_out.

## Interface
- WIDTH, 8: divisor/counter width in bits, ≥1
- CHANNELS, 2: number of independent divider channels, ≥1
- SELW, $clog2(CHANNELS) floored at 1: width of div_sel (localparam)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ch_en  in  CHANNELS  per-channel run enable
- div_load  in  1  single-cycle strobe: write div_value/div_mode into channel div_sel
- div_sel  in  SELW  target channel; values ≥ CHANNELS are ignored (no write)
- div_value  in  WIDTH  divisor D; the channel wraps every D+1 enabled cycles
- div_mode  in  1  0 = toggle (≈50% duty), 1 = pulse (one-cycle high per wrap)
- sync  in  1  strobe: restart phase of all channels
- clk_out  out  CHANNELS  divided outputs, registered
- tick  out  CHANNELS  one-cycle strobe per wrap, registered, mode-independent

## Operation
- Per-channel state: cnt[WIDTH], active divisor act_d, shadow divisor shd_d, mode, clk_out, tick.
- Reset (rst_n=0 at an edge) sets all of the following to 0 on that edge: cnt, act_d, shd_d, mode, clk_out, tick.
- Load: div_load with a valid div_sel writes shd_d←div_value and shd_mode←div_mode on that edge.
- Apply rule: shadow contents copy into act_d/mode in three cases:
  - at the edge where the channel wraps;
  - on any edge where ch_en is low;
  - on a sync edge.
- Load coinciding with wrap/disable/sync: the incoming div_value is applied directly (write-through). It is never lost or delayed.
- Enabled, no sync, cnt==act_d: cnt←0 and tick←1. In toggle mode clk_out←~clk_out; in pulse mode clk_out←1.
- Enabled, no sync, cnt≠act_d: cnt←cnt+1, tick←0; pulse mode clk_out←0, toggle mode holds.
- Disabled (ch_en=0): cnt←0, tick←0, clk_out←0.
- sync=1: every channel gets cnt←0, tick←0, clk_out←0, regardless of enable.
  - sync beats a coincident wrap: no tick is emitted.
- Mode change takes effect at the apply point. In toggle mode, clk_out restarts from its current level.
- Arithmetic: cnt is unsigned WIDTH-bit. Comparison is equality only, so cnt never exceeds act_d.
  - act_d=2^WIDTH−1 gives a 2^WIDTH-cycle period with no overflow.

## Timing
- All outputs registered; no combinational input→output path.
- Wrap period: D+1 cycles. Toggle mode: clk_out period 2(D+1), high for D+1. Pulse mode: clk_out high 1 of every D+1 cycles.
- D=0: tick high every cycle; toggle clk_out = clk/2; pulse clk_out constantly 1.
- First tick after enable:
  - if ch_en is sampled high on edges k…k+D, tick is high after edge k+D;
  - the same latency applies after a sync at edge s: first tick after edge s+D+1.
- Load latency while running: no effect until the current period finishes with the old D. The next period uses the new D.
- Reset mid-operation clears everything on the same edge. Outputs read 0 the cycle after.

## Structure
- Package clk_div_pkg holds:
  - mode constants MODE_TOGGLE=1'b0, MODE_PULSE=1'b1;
  - default WIDTH/CHANNELS values.
- Sub-module clk_div_channel implements one channel (ports: clk, rst_n, en, sync, ld, ld_value, ld_mode, clk_out, tick).
- clk_div_multi decodes div_sel into per-channel ld strobes and instantiates CHANNELS copies via generate.

## Test plan
- Reset, then ch_en=1 with D=0 on ch0 -> tick0 high every cycle; clk_out0 toggles every cycle; all outputs were 0 during reset.
- Load ch1 D=3, toggle mode, enable -> first tick 4 edges after enable; clk_out1 period 8 cycles, 4 high / 4 low.
- ch0 running D=4, load D=1 mid-period -> current period completes at 5 cycles, then wraps every 2; no short or glitch pulse.
- Pulse mode D=2 on ch0 and toggle D=5 on ch1, then sync on the cycle ch0 would wrap -> no tick on that edge; both clk_out go 0; next ticks at +3 and +6 edges.
- div_sel=CHANNELS (out of range) with div_load -> no channel divisor changes. Also drop ch_en mid-period -> clk_out/tick go 0 next cycle and cnt restarts on re-enable.
- Load D=255 (WIDTH=8) in pulse mode -> tick exactly every 256 cycles; assert rst_n=0 mid-count -> all outputs 0 after that edge, act_d reads back as 0 (tick every cycle when re-enabled).
